eb_two_slot: RTL
================

Name: eb_two_slot

Overview:
- 2-slot elastic buffer (skid buffer) on the valid/ready protocol used across the pipeline.
- Sustains 100% throughput while driving both ready_out and valid_out straight from flops. No combinational path from ready_in to ready_out, and none from valid_in to valid_out.
- Inserted wherever the back-notification (ready) path must be cut for timing, e.g. long issue/writeback stalls and vector lane boundaries.
- Complements the 1-slot buffers, which cut only the forward path or halve throughput.

Parameters:
- DATA_WIDTH, 16, payload width in bits.
- GATING_FRIENDLY, 1'b1, data regs written only on an accepted transfer (1), or loaded freely whenever the slot would accept (0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  upstream valid.
- ready_out  out  1  upstream ready, registered.
- data_in  in  DATA_WIDTH  upstream payload.
- valid_out  out  1  downstream valid, registered.
- ready_in  in  1  downstream ready.
- data_out  out  DATA_WIDTH  downstream payload, equals the main register.
- count  out  2  occupancy, 0..2.

Behaviour:
- Storage: main_r (output slot) and aux_r (skid slot).
- State: EMPTY(0), HALF(1), FULL(2); count equals the state encoding.
- Reset: state=EMPTY, so valid_out=0, ready_out=1, count=0. Data regs are not reset; data_out is don't-care while valid_out=0.
- ready_out = (state!=FULL), decoded from the state flop only.
- valid_out = (state!=EMPTY).
- push = valid_in & ready_out; pop = valid_out & ready_in.
- EMPTY:
  - push -> HALF, main_r<=data_in.
  - ready_in ignored, since pop=0.
- HALF:
  - push & pop -> HALF, main_r<=data_in.
  - push & !pop -> FULL, aux_r<=data_in, main_r holds.
  - pop & !push -> EMPTY.
  - neither -> hold.
- FULL:
  - pop -> HALF, main_r<=aux_r.
  - push is impossible because ready_out=0; valid_in is ignored.
- Latency: 1 cycle from accepted input to valid_out.
- Throughput: 1 transfer/cycle in steady state with ready_in=1.
- Ordering: strict FIFO; aux_r always holds the younger item.
- Protocol, both sides:
  - Once valid_out=1, data_out is stable until pop.
  - Upstream may drop valid_in at any time; a transfer occurs only on push.
- Downstream stall: a ready_in drop is absorbed by aux_r. ready_out deasserts one cycle later (registered); that one-cycle lag is exactly the purpose of the skid slot.
- GATING_FRIENDLY=0:
  - main_r<=data_in on every cycle where state==EMPTY, or state==HALF and pop.
  - aux_r<=data_in on every cycle where state==HALF and !pop.
  - State transitions are identical to GATING_FRIENDLY=1, and visible outputs are unchanged whenever valid_out=1.
- Reset mid-operation: both slots are dropped immediately (asynchronous); the buffer is EMPTY with ready_out=1 on rst deassertion.
- No combinational loops. A valid_in change never alters ready_out in the same cycle.

Test Plan:
- Reset & idle: assert rst mid-run with count=2 -> valid_out=0, ready_out=1, count=0 immediately; after release with valid_in=0 for 5 cycles, valid_out stays 0.
- Streaming: send 0x0001..0x0010 with ready_in=1 every cycle -> data_out=0x0001 one cycle after the first push, then one new word per cycle in order; count stays 1 and ready_out stays 1 throughout.
- Skid:
  - Stream 0xA0,0xA1,0xA2 with ready_in dropped in the cycle 0xA1 is offered -> 0xA1 is accepted into aux_r, count=2, ready_out=0 next cycle, 0xA2 held upstream.
  - ready_in=1 again -> outputs 0xA0,0xA1,0xA2 in order with no loss or duplication.
- Full stall: fill with 0x11,0x22, then hold ready_in=0 for 10 cycles while valid_in=1 with 0x33 -> data_out=0x11 stable, count=2, ready_out=0, 0x33 not accepted; after release, output order is 0x11,0x22,0x33.
- Drain: HALF holding 0x55, valid_in=0, ready_in=1 -> 0x55 popped, next cycle valid_out=0, count=0.
- Random: random valid_in/ready_in (50%/50%) over 10k cycles with a scoreboard, for both GATING_FRIENDLY=0 and GATING_FRIENDLY=1 -> FIFO order holds and no drops or duplicates. Assertions:
  - ready_out==(count!=2).
  - valid_out==(count!=0).
  - data_out stable while valid_out & !ready_in.

Source files
------------

// File: rtl/eb_two_slot.sv
// Two-slot elastic (skid) buffer on valid/ready; ready_out and valid_out come straight from the state flop.
// Latency: 1 cycle from accepted input to valid_out; sustains one transfer per cycle.
// Backpressure: a ready_in drop is absorbed by the skid slot; ready_out falls one cycle later, only when both slots are full.
module eb_two_slot #(
    parameter int DATA_WIDTH      = 16,
    parameter bit GATING_FRIENDLY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] aux_r;
    logic                  push;
    logic                  pop;
    logic                  main_ld_in;
    logic                  main_ld_aux;
    logic                  aux_ld;

    // Handshake outputs depend on the state flop only, never on valid_in/ready_in.
    assign ready_out = (state_r != FULL);
    assign valid_out = (state_r != EMPTY);
    assign count     = state_r;
    assign data_out  = main_r;

    assign push = valid_in & ready_out;
    assign pop  = valid_out & ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            EMPTY: begin
                if (push) begin
                    state_nxt = HALF;
                end
            end
            HALF: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = HALF;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Draining from FULL promotes the younger skid entry into the output slot.
    assign main_ld_aux = (state_r == FULL) & pop;

    generate
        if (GATING_FRIENDLY) begin : g_gated
            assign main_ld_in = push & ((state_r == EMPTY) | ((state_r == HALF) & pop));
            assign aux_ld     = push & (state_r == HALF) & ~pop;
        end else begin : g_free
            // Slots load whenever they could accept; stale loads are hidden because state does not advance.
            assign main_ld_in = (state_r == EMPTY) | ((state_r == HALF) & pop);
            assign aux_ld     = (state_r == HALF) & ~pop;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (main_ld_aux) begin
            main_r <= aux_r;
        end else if (main_ld_in) begin
            main_r <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (aux_ld) begin
            aux_r <= data_in;
        end
    end

endmodule
